sram_test_seq: RTL and testbench
================================

SRAM_TEST_SEQ -- requirements
Module: sram_test_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter LAST_ADDR, default 19'h7FFFF: highest address tested, starting from 0.
REQ-003 Parameter WAIT_CYC, default 2, minimum 2: cycles per access hold.
REQ-004 clk  input  1  system clock, all state on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that launches a test from IDLE or DONE.
REQ-007 seed  input  8  pattern seed, sampled on an accepted start.
REQ-008 rw  output  1  SRAM controller read (1) / write (0) select.
REQ-009 addr  output  19  SRAM controller address.
REQ-010 data_f2s  output  8  write data to the SRAM controller.
REQ-011 data_s2f_r  input  8  registered read data from the SRAM controller.
REQ-012 busy  output  1  high while the test runs.
REQ-013 done  output  1  high from test completion until the next accepted start.
REQ-014 pass  output  1  done AND err_count==0.
REQ-015 err_count  output  16  mismatch count, saturating at 16'hFFFF.
REQ-016 first_err_addr  output  19  address of the first mismatch; 0 if there is none.

Function
REQ-017 The test SHALL run four phases in order:
- P0 writes E(a) = a[7:0] XOR seed_r.
- P1 reads and checks E(a).
- P2 writes ~E(a).
- P3 reads and checks ~E(a).
REQ-018 Each phase SHALL sweep a = 0..LAST_ADDR ascending.
REQ-019 The state set SHALL be IDLE, WR_SET, WR_PULSE, WR_REC, RD_ADDR, RD_CMP, DONE.
REQ-020 IDLE/DONE + start SHALL do all of the following:
- latch seed_r;
- clear err_count, first_err_addr, done and the first-error flag;
- set a=0 and enter WR_SET with phase P0.
REQ-021 WR_SET SHALL last 1 cycle, with rw=1 and addr/data_f2s valid.
REQ-022 WR_PULSE SHALL last WAIT_CYC cycles with rw=0.
REQ-023 WR_REC SHALL last 1 cycle with rw=1.
REQ-024 In WR_REC, addr and data_f2s SHALL still hold their WR_SET values; the address advances on exit.
REQ-025 addr and data_f2s SHALL NOT change while rw=0.
REQ-026 rw SHALL be 1 on every cycle in which addr changes.
REQ-027 RD_ADDR SHALL last WAIT_CYC cycles with rw=1 and addr=a.
REQ-028 RD_CMP SHALL last 1 cycle, with rw=1 and addr held.
REQ-029 In RD_CMP, data_s2f_r SHALL be compared against the phase's expected value.
REQ-030 On a mismatch, err_count SHALL increment unless it is already 16'hFFFF.
REQ-031 On the first mismatch of a test only, first_err_addr SHALL capture a.
REQ-032 After the last state for a=LAST_ADDR (WR_REC or RD_CMP):
- a SHALL wrap to 0;
- the next phase SHALL start in WR_SET (P2) or RD_ADDR (P1, P3);
- after P3 the block SHALL enter DONE.
REQ-033 The cycle count per address SHALL be WAIT_CYC+2 in write phases and WAIT_CYC+1 in read phases.
REQ-034 The total cycle count from the start edge to done=1 SHALL be 2*(LAST_ADDR+1)*(2*WAIT_CYC+3).
REQ-035 start SHALL be ignored while busy=1.
REQ-036 start in DONE SHALL restart the test per REQ-020.
REQ-037 busy SHALL be high in every state except IDLE and DONE.
REQ-038 done SHALL be high only in DONE.
REQ-039 In IDLE and DONE, rw SHALL be 1 and addr SHALL hold its last value.
REQ-040 data_f2s SHALL be a registered output.
REQ-041 rw SHALL be decoded from the registered state, glitch-free.

Reset
REQ-042 While reset=0, asynchronously:
- state SHALL be IDLE and rw SHALL be 1;
- addr, data_f2s, seed_r and the phase SHALL be 0;
- busy, done, pass SHALL be 0;
- err_count and first_err_addr SHALL be 0.
REQ-043 A reset assertion mid-test SHALL abort the test immediately with the values of REQ-042.
REQ-044 After a mid-test abort, no write pulse SHALL be completed or extended.
REQ-045 The first active edge after reset release SHALL see state IDLE.

Verification
REQ-046 All scenarios SHALL use LAST_ADDR=3, WAIT_CYC=2, seed=8'hA5, and a behavioural SRAM behind the controller.
REQ-047 Scenario reset values: drive reset=0 -> rw=1, addr=0, busy=0, done=0, err_count=0.
REQ-048 Scenario good memory: start -> done=1 exactly 56 cycles after the start edge, pass=1, err_count=0.
REQ-049 Good memory, P0 writes: the write pulses carry data 8'hA5, A4, A7, A6.
REQ-050 Good memory, P2 writes: the write pulses carry data 8'h5A, 5B, 58, 59.
REQ-051 Scenario stuck-at-0 on bit0 of address 2 -> err_count=1, first_err_addr=2, pass=0.
REQ-052 In the stuck-bit scenario, the P1 mismatch SHALL be read 8'hA6 against expected 8'hA7.
REQ-053 Scenario address bit1 ignored by the model (aliasing) -> err_count=4, first_err_addr=0.
REQ-054 Scenario start pulses during busy -> no restart and the cycle total is still 56.
REQ-055 Scenario start in DONE -> err_count and first_err_addr cleared and a rerun completes.
REQ-056 Scenario reset=0 during a P2 WR_PULSE -> rw=1 in the same cycle, busy=0, done=0.
REQ-057 After the REQ-056 abort, the next start SHALL run a full 56-cycle test.

Source files
------------

// File: rtl/sram_test_seq.sv
// March-style SRAM self-test sequencer: write/verify a seeded pattern, then its
// complement, over addresses 0..LAST_ADDR, counting mismatches.
//   state    | meaning
//   IDLE     | waiting for start after reset
//   WR_SET   | address/data set up, rw high
//   WR_PULSE | write strobe (rw low) for WAIT_CYC cycles
//   WR_REC   | write recovery, address/data still held
//   RD_ADDR  | read address presented for WAIT_CYC cycles
//   RD_CMP   | compare registered read data
//   DONE     | results valid until next start
module sram_test_seq #(
  parameter logic [18:0] LAST_ADDR = 19'h7FFFF,
  parameter int unsigned WAIT_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  seed,
  output logic        rw,
  output logic [18:0] addr,
  output logic [7:0]  data_f2s,
  input  logic [7:0]  data_s2f_r,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [18:0] first_err_addr
);

  localparam int CW = $clog2(WAIT_CYC);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SET, S_WR_PULSE, S_WR_REC, S_RD_ADDR, S_RD_CMP, S_DONE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_phase;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_seed;
  logic          r_rw;
  logic [18:0]   r_addr;
  logic [7:0]    r_data;
  logic          r_busy;
  logic          r_done;
  logic [15:0]   r_err;
  logic [18:0]   r_fea;
  logic          r_first_seen;

  logic [18:0]   w_addr_nxt;
  logic [7:0]    w_exp;
  logic          w_last;

  // Phases 2 and 3 use the complemented pattern.
  function automatic logic [7:0] f_pat(input logic [18:0] a, input logic [7:0] s,
                                       input logic inv);
    return (a[7:0] ^ s) ^ {8{inv}};
  endfunction

  assign w_addr_nxt = r_addr + 19'd1;
  assign w_exp      = f_pat(r_addr, r_seed, r_phase[1]);
  assign w_last     = (r_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_phase      <= 2'd0;
      r_cnt        <= '0;
      r_seed       <= 8'd0;
      r_rw         <= 1'b1;
      r_addr       <= 19'd0;
      r_data       <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 16'd0;
      r_fea        <= 19'd0;
      r_first_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_seed       <= seed;
            r_err        <= 16'd0;
            r_fea        <= 19'd0;
            r_first_seen <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_phase      <= 2'd0;
            r_addr       <= 19'd0;
            r_data       <= f_pat(19'd0, seed, 1'b0);
            r_rw         <= 1'b1;
            r_state      <= S_WR_SET;
          end
        end
        S_WR_SET: begin
          r_rw    <= 1'b0;
          r_cnt   <= CNT_LOAD;
          r_state <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (r_cnt == '0) begin
            r_rw    <= 1'b1;
            r_state <= S_WR_REC;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WR_REC: begin
          if (w_last) begin
            r_addr  <= 19'd0;
            r_phase <= r_phase + 2'd1;
            r_cnt   <= CNT_LOAD;
            r_state <= S_RD_ADDR;
          end else begin
            r_addr  <= w_addr_nxt;
            r_data  <= f_pat(w_addr_nxt, r_seed, r_phase[1]);
            r_state <= S_WR_SET;
          end
        end
        S_RD_ADDR: begin
          if (r_cnt == '0) r_state <= S_RD_CMP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_RD_CMP: begin
          if (data_s2f_r != w_exp) begin
            if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            if (!r_first_seen) begin
              r_fea        <= r_addr;
              r_first_seen <= 1'b1;
            end
          end
          if (!w_last) begin
            r_addr  <= w_addr_nxt;
            r_cnt   <= CNT_LOAD;
            r_state <= S_RD_ADDR;
          end else if (r_phase == 2'd1) begin
            r_addr  <= 19'd0;
            r_phase <= 2'd2;
            r_data  <= f_pat(19'd0, r_seed, 1'b1);
            r_state <= S_WR_SET;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_rw    <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rw             = r_rw;
  assign addr           = r_addr;
  assign data_f2s       = r_data;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_done && (r_err == 16'd0);
  assign err_count      = r_err;
  assign first_err_addr = r_fea;

endmodule

// File: tb/tb_sram_test_seq.sv
// Bench for sram_test_seq: behavioural SRAM with injectable faults, an abstract
// march-test model feeding a scoreboard, and a monitor that checks write pulses and results.
module tb_sram_test_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  seed = 8'd0;
  logic        rw;
  logic [18:0] addr;
  logic [7:0]  data_f2s;
  logic [7:0]  data_s2f_r = 8'd0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [18:0] first_err_addr;

  sram_test_seq #(.LAST_ADDR(19'd3), .WAIT_CYC(2)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .rw(rw), .addr(addr),
    .data_f2s(data_f2s), .data_s2f_r(data_s2f_r), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  longint start_cyc = 0;
  int mode = 0; // 0 good, 1 bit0 of address 2 stuck at 0, 2 address bit1 ignored

  typedef struct { logic [18:0] a; logic [7:0] d; } wr_t;
  typedef struct { int errs; logic [18:0] fea; logic ps; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  logic [7:0] mem [4];

  function automatic logic [1:0] phys(input logic [1:0] a, input int m);
    return (m == 2) ? (a & 2'b01) : a;
  endfunction

  function automatic logic [7:0] stored(input logic [1:0] p, input logic [7:0] d, input int m);
    return (m == 1 && p == 2'd2) ? (d & 8'hFE) : d;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rw) mem[phys(addr[1:0], mode)] <= stored(phys(addr[1:0], mode), data_f2s, mode);
    data_s2f_r <= mem[phys(addr[1:0], mode)];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: run the four phases over a private memory, with the same fault applied.
  task automatic push_expect(input logic [7:0] sd, input int m, input int wr_limit,
                             input bit with_done);
    logic [7:0]  mm [4];
    logic [7:0]  e;
    logic [1:0]  p;
    int          nerr = 0;
    int          nwr = 0;
    logic [18:0] fea = 19'd0;
    bit          seen = 0;
    wr_t         w;
    dn_t         dd;
    for (int ph = 0; ph < 4; ph++) begin
      for (int a = 0; a < 4; a++) begin
        e = 8'(a) ^ sd;
        if (ph >= 2) e = ~e;
        p = phys(2'(a), m);
        if (ph % 2 == 0) begin
          if (nwr < wr_limit) begin
            w.a = 19'(a); w.d = e;
            wr_q.push_back(w);
          end
          nwr++;
          mm[p] = stored(p, e, m);
        end else if (mm[p] != e) begin
          nerr++;
          if (!seen) begin fea = 19'(a); seen = 1; end
        end
      end
    end
    if (with_done) begin
      dd.errs = nerr; dd.fea = fea; dd.ps = (nerr == 0);
      dn_q.push_back(dd);
    end
  endtask

  logic        prev_rw = 1'b1;
  logic        prev_done = 1'b0;
  logic [18:0] prev_addr = 19'd0;
  logic [7:0]  prev_data = 8'd0;
  wr_t         mw;
  dn_t         md;

  always @(negedge clk) begin
    if (reset) begin
      if (!rw && prev_rw) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_pulse: got unexpected pulse addr %0h data %0h", addr, data_f2s);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", 64'(addr), 64'(mw.a));
          chk("wr_data", 64'(data_f2s), 64'(mw.d));
        end
      end else if (!rw && !prev_rw) begin
        chk("hold_addr", 64'(addr), 64'(prev_addr));
        chk("hold_data", 64'(data_f2s), 64'(prev_data));
      end
      if (done && !prev_done) begin
        if (dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_event: got unexpected done err_count %0h", err_count);
        end else begin
          md = dn_q.pop_front();
          chk("err_count", 64'(err_count), 64'(md.errs));
          chk("first_err_addr", 64'(first_err_addr), 64'(md.fea));
          chk("pass", 64'(pass), 64'(md.ps));
          chk("cycles", 64'(cyc - start_cyc), 64'd56);
        end
      end
    end
    prev_rw   = rw;
    prev_done = done;
    prev_addr = addr;
    prev_data = data_f2s;
  end

  task automatic do_start(input logic [7:0] sd);
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_done: got timeout after %0d cycles expected done", n);
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [7:0] sd, input int m);
    mode = m;
    push_expect(sd, m, 8, 1);
    do_start(sd);
    wait_done();
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_rw", 64'(rw), 64'd1);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run(8'hA5, 0);
    run(8'hA5, 1);

    // Restart from DONE with a healthy memory; results must clear on the start edge.
    mode = 0;
    push_expect(8'hA5, 0, 8, 1);
    do_start(8'hA5);
    chk("restart_err_clr", 64'(err_count), 64'd0);
    chk("restart_fea_clr", 64'(first_err_addr), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_done();

    run(8'hA5, 2);

    // Start pulses while busy must be ignored.
    mode = 0;
    push_expect(8'hA5, 0, 8, 1);
    do_start(8'hA5);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(2, 8)) @(negedge clk);
      seed  = 8'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();

    // Abort during the first P2 write pulse.
    mode = 0;
    push_expect(8'hA5, 0, 5, 0);
    do_start(8'hA5);
    begin
      int   nf = 0;
      logic pr = 1'b1;
      for (int i = 0; i < 200 && nf < 5; i++) begin
        @(negedge clk);
        if (!rw && pr) nf++;
        pr = rw;
      end
      if (nf < 5) begin
        checks++; errors++;
        $display("FAIL abort_wait: got %0d write pulses expected 5", nf);
      end
    end
    #2 reset = 1'b0;
    #1;
    chk("abort_rw", 64'(rw), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_addr", 64'(addr), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(8'hA5, 0);

    for (int r = 0; r < 3; r++) begin
      run(8'($urandom), int'($urandom_range(0, 2)));
    end

    chk("wr_q_left", 64'(wr_q.size()), 64'd0);
    chk("dn_q_left", 64'(dn_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
